// File: rtl/decoder_nseq.sv
// Registered N-to-2^N decoder (one-hot / thermometer / scan / inverted) with a self-timed scan sequencer.
// Latency 1 cycle from accept to y/y_valid; in_ready drops while disabled, scanning, or on a mode-change cycle.
module decoder_nseq #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic [SEL_W-1:0] scan_pos,
  output logic             wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] M_ONEHOT = 2'b00;
  localparam logic [1:0] M_THERM  = 2'b01;
  localparam logic [1:0] M_SCAN   = 2'b10;
  localparam logic [1:0] M_INV    = 2'b11;

  logic [1:0]       r_mode;
  logic [DW_W-1:0]  r_dwell;
  logic [SEL_W-1:0] r_scan_pos;
  logic [OUT_W-1:0] r_y;
  logic             r_y_valid;
  logic             r_wrap;

  logic             w_mode_chg;
  logic             w_accept;
  logic             w_dwell_end;
  logic [SEL_W-1:0] w_next_pos;
  logic [OUT_W-1:0] w_onehot;
  logic [OUT_W-1:0] w_therm;
  logic [OUT_W-1:0] w_scan_y;

  assign w_mode_chg  = en & (mode != r_mode);
  assign in_ready    = en & (mode != M_SCAN) & (mode == r_mode);
  assign w_accept    = in_valid & in_ready;

  assign w_onehot    = OUT_W'(1) << sel;
  // Shifting the one-hot left drops the top bit for sel=OUT_W-1, so the subtract wraps to all ones.
  assign w_therm     = (w_onehot << 1) - OUT_W'(1);

  assign w_dwell_end = (r_dwell == DW_W'(DWELL - 1));
  assign w_next_pos  = r_scan_pos + SEL_W'(1);
  assign w_scan_y    = OUT_W'(1) << w_next_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= M_ONEHOT;
      r_dwell    <= '0;
      r_scan_pos <= '0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
      r_wrap     <= 1'b0;
    end else if (!en) begin
      r_y_valid <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (w_mode_chg) begin
      r_mode     <= mode;
      r_dwell    <= '0;
      r_scan_pos <= '0;
      r_wrap     <= 1'b0;
      case (mode)
        M_SCAN: begin
          r_y       <= OUT_W'(1);
          r_y_valid <= 1'b1;
        end
        M_INV: begin
          r_y       <= '1;
          r_y_valid <= 1'b0;
        end
        default: begin
          r_y       <= '0;
          r_y_valid <= 1'b0;
        end
      endcase
    end else if (r_mode == M_SCAN) begin
      if (w_dwell_end) begin
        r_dwell    <= '0;
        r_scan_pos <= w_next_pos;
        r_y        <= w_scan_y;
        r_y_valid  <= 1'b1;
        r_wrap     <= (r_scan_pos == SEL_W'(OUT_W - 1));
      end else begin
        r_dwell   <= r_dwell + DW_W'(1);
        r_y_valid <= 1'b0;
        r_wrap    <= 1'b0;
      end
    end else begin
      r_wrap    <= 1'b0;
      r_y_valid <= w_accept;
      if (w_accept) begin
        case (r_mode)
          M_THERM: r_y <= w_therm;
          M_INV:   r_y <= ~w_onehot;
          default: r_y <= w_onehot;
        endcase
      end
    end
  end

  assign y        = r_y;
  assign y_valid  = r_y_valid;
  assign scan_pos = r_scan_pos;
  assign wrap     = r_wrap;

endmodule
